packet_forwarder: RTL and testbench

Serializer stage directly downstream of the packet reassembly buffer. Pops one completed packet from the reassembly buffer's completed-packet output, snapshots its flits into a local register file, and releases the buffer entry in the same cycle. It then streams the flits, HEAD first, onto a valid/ready flit port toward the local consumer. An optional stall watchdog aborts packets whose output is blocked too long.

---
 rtl/packet_types_pkg.sv | 21 ++
 rtl/types_pkg.sv | 17 +
 rtl/packet_forwarder_stall_watchdog.sv | 29 ++
 rtl/packet_forwarder.sv | 107 ++++++++++
 tb/tb_packet_forwarder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_types_pkg.sv
// Packet-level types shared by the reassembly buffer and the forwarder.
// The packet capacity here must match the forwarder's MAX_NUM_OF_FLIT.
package packet_types;

  localparam int PKT_CAPACITY     = 8;
  localparam int TAIL_INDEX_WIDTH = 8;
  localparam int FLIT_IDX_WIDTH   = $clog2(PKT_CAPACITY + 1);

  typedef logic [FLIT_IDX_WIDTH-1:0] flit_idx_t;

  typedef enum logic {
    IDLE,
    SEND
  } forwarder_state_t;

  typedef struct packed {
    types::flit_t [PKT_CAPACITY-1:0]  buffer;
    logic [TAIL_INDEX_WIDTH-1:0]      tail_index;
  } packet_element_t;

endpackage

// File: rtl/types_pkg.sv
// Flit format shared by the NoC endpoints.
// Two-bit flit type plus a 30-bit payload.
package types;

  typedef enum logic [1:0] {
    HEAD,
    BODY,
    TAIL,
    HEADTAIL
  } flittype_t;

  typedef struct packed {
    flittype_t   flittype;
    logic [29:0] data;
  } flit_t;

endpackage

// File: rtl/packet_forwarder_stall_watchdog.sv
// Counts consecutive stalled cycles; expired fires on the
// stalled cycle that completes the TIMEOUT-th stall.
module stall_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = tick && !clear && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || expired) begin
      count <= '0;
    end else if (tick) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/packet_forwarder.sv
// Pops completed packets and streams their flits over valid/ready.
// Optional stall abort: define PACKET_FORWARDER_STALL_TIMEOUT_EN.
module packet_forwarder
  import types::*;
  import packet_types::*;
#(
  parameter int MAX_NUM_OF_FLIT  = 8,
  parameter int STALL_TIMEOUT    = 64,
  parameter int DROP_COUNT_WIDTH = 16
) (
  input  logic                        nocclk,
  input  logic                        rst,
  input  packet_element_t             transfered_packet,
  input  logic                        transfered_packet_valid,
  output logic                        transfered_packet_completed,
  output flit_t                       out_flit,
  output logic                        out_flit_valid,
  input  logic                        out_flit_ready,
  output logic                        busy,
  output logic [DROP_COUNT_WIDTH-1:0] dropped_count
);

  localparam int IW = $clog2(MAX_NUM_OF_FLIT + 1);
  localparam int SW = (MAX_NUM_OF_FLIT > 1) ? $clog2(MAX_NUM_OF_FLIT) : 1;
  localparam logic [TAIL_INDEX_WIDTH-1:0] MAX_TI =
    TAIL_INDEX_WIDTH'(MAX_NUM_OF_FLIT);

  forwarder_state_t state;
  flit_t            snap [2**SW];
  logic [IW-1:0]    idx;
  logic [IW-1:0]    len;
  logic             legal;
  logic             fire;
  logic             last;
  logic             abort;
  logic             drop;
  logic             pop;

  // Full-width compare so oversized lengths cannot alias after truncation.
  assign legal = (transfered_packet.tail_index != '0) &&
                 (transfered_packet.tail_index <= MAX_TI);

  assign busy           = (state == SEND);
  assign out_flit_valid = busy;
  assign out_flit       = busy ? snap[idx[SW-1:0]] : '0;
  assign pop            = !busy && transfered_packet_valid;

  assign transfered_packet_completed = pop && !rst;

  assign fire = out_flit_valid && out_flit_ready;
  assign last = (idx == len - IW'(1));
  assign drop = (pop && !legal) || abort;

`ifdef PACKET_FORWARDER_STALL_TIMEOUT_EN
  stall_watchdog #(
    .TIMEOUT (STALL_TIMEOUT)
  ) u_watchdog (
    .clk     (nocclk),
    .rst     (rst),
    .clear   (!busy || fire),
    .tick    (out_flit_valid && !out_flit_ready),
    .expired (abort)
  );
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge nocclk) begin
    if (pop) begin
      for (int i = 0; i < MAX_NUM_OF_FLIT; i++) begin
        snap[i] <= transfered_packet.buffer[i];
      end
    end
  end

  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      len           <= '0;
      dropped_count <= '0;
    end else begin
      if (drop && !(&dropped_count)) begin
        dropped_count <= dropped_count + DROP_COUNT_WIDTH'(1);
      end
      unique case (state)
        IDLE: begin
          if (transfered_packet_valid) begin
            idx <= '0;
            len <= transfered_packet.tail_index[IW-1:0];
            if (legal) state <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            state <= IDLE;
          end else if (fire) begin
            idx <= idx + IW'(1);
            if (last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_forwarder.sv
// Directed bench for packet_forwarder with a queue-based reference model.
// Works with and without PACKET_FORWARDER_STALL_TIMEOUT_EN.
module tb_packet_forwarder;
  import types::*;
  import packet_types::*;

  localparam int MAXF = 8;
  localparam int TO   = 4;
  localparam int DW   = 2;
  localparam int DMAX = (1 << DW) - 1;
`ifdef PACKET_FORWARDER_STALL_TIMEOUT_EN
  localparam int BASE = 1;
`else
  localparam int BASE = 0;
`endif

  logic            nocclk;
  logic            rst;
  packet_element_t pkt;
  logic            pvalid;
  logic            completed;
  flit_t           oflit;
  logic            ovalid;
  logic            oready;
  logic            busy;
  logic [DW-1:0]   dropped;

  int checks = 0;
  int errors = 0;

  packet_forwarder #(
    .MAX_NUM_OF_FLIT  (MAXF),
    .STALL_TIMEOUT    (TO),
    .DROP_COUNT_WIDTH (DW)
  ) dut (
    .nocclk                      (nocclk),
    .rst                         (rst),
    .transfered_packet           (pkt),
    .transfered_packet_valid     (pvalid),
    .transfered_packet_completed (completed),
    .out_flit                    (oflit),
    .out_flit_valid              (ovalid),
    .out_flit_ready              (oready),
    .busy                        (busy),
    .dropped_count               (dropped)
  );

  initial nocclk = 1'b0;
  always #5 nocclk = ~nocclk;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               name, $time, got, exp);
    end
  endtask

  function automatic flit_t fl(flittype_t t, int d);
    flit_t f;
    f.flittype = t;
    f.data = 30'(d);
    return f;
  endfunction

  function automatic packet_element_t mk(int n, int tag, int ti);
    packet_element_t p;
    p = '0;
    for (int i = 0; i < PKT_CAPACITY; i++) begin
      if (i >= n)          p.buffer[i].flittype = BODY;
      else if (n == 1)     p.buffer[i].flittype = HEADTAIL;
      else if (i == 0)     p.buffer[i].flittype = HEAD;
      else if (i == n - 1) p.buffer[i].flittype = TAIL;
      else                 p.buffer[i].flittype = BODY;
      p.buffer[i].data = 30'(tag * 16 + i);
    end
    p.tail_index = 8'(ti);
    return p;
  endfunction

  // Reference model: flits still owed to the consumer, in order.
  flit_t exp_q[$];
  int    stall = 0;
  int    mdrop = 0;

  initial forever begin
    @(posedge nocclk or posedge rst);
    if (rst) begin
      exp_q.delete();
      stall = 0;
      mdrop = 0;
    end else if (exp_q.size() == 0) begin
      if (pvalid) begin
        int n;
        n = int'(pkt.tail_index);
        if (n >= 1 && n <= MAXF) begin
          for (int i = 0; i < n; i++) exp_q.push_back(pkt.buffer[i]);
        end else begin
          mdrop = (mdrop == DMAX) ? DMAX : mdrop + 1;
        end
      end
    end else if (oready) begin
      void'(exp_q.pop_front());
      stall = 0;
    end else begin
      stall++;
`ifdef PACKET_FORWARDER_STALL_TIMEOUT_EN
      if (stall == TO) begin
        exp_q.delete();
        stall = 0;
        mdrop = (mdrop == DMAX) ? DMAX : mdrop + 1;
      end
`endif
    end
  end

  initial forever begin
    @(negedge nocclk);
    if (!rst) begin
      logic hold;
      hold = (exp_q.size() > 0);
      chk("m_valid", ovalid, hold);
      chk("m_busy", busy, hold);
      chk("m_completed", completed, !hold && pvalid);
      chk("m_flit", oflit, hold ? exp_q[0] : flit_t'('0));
      chk("m_dropped", dropped, mdrop);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge nocclk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    pvalid = 1'b0;
    oready = 1'b1;
    pkt = '0;
    #2;
    chk("rst_valid", ovalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_completed", completed, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_flit", oflit, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // back-to-back 3-flit then 2-flit packet
    pkt = mk(3, 1, 3); pvalid = 1'b1; #1;
    chk("t1_pop", completed, 1);
    step();
    pkt = mk(2, 2, 2); #1;
    chk("t1_f0_valid", ovalid, 1);
    chk("t1_f0", oflit, fl(HEAD, 'h10));
    chk("t1_nopop", completed, 0);
    step(); #1; chk("t1_f1", oflit, fl(BODY, 'h11));
    step(); #1; chk("t1_f2", oflit, fl(TAIL, 'h12));
    step(); #1;
    chk("t1_idle", busy, 0);
    chk("t1_pop2", completed, 1);
    step();
    pvalid = 1'b0; #1;
    chk("t1_b0", oflit, fl(HEAD, 'h20));
    step(); #1; chk("t1_b1", oflit, fl(TAIL, 'h21));
    step(); #1; chk("t1_end", busy, 0);

    // backpressure on flit 1 for three cycles
    pkt = mk(3, 3, 3); pvalid = 1'b1; #1;
    chk("t2_pop", completed, 1);
    step(); pvalid = 1'b0; #1; chk("t2_f0", oflit, fl(HEAD, 'h30));
    step(); oready = 1'b0; #1; chk("t2_h1", oflit, fl(BODY, 'h31));
    step(); #1;
    chk("t2_h2", oflit, fl(BODY, 'h31));
    chk("t2_h2v", ovalid, 1);
    step(); #1; chk("t2_h3", oflit, fl(BODY, 'h31));
    step(); oready = 1'b1; #1; chk("t2_f1", oflit, fl(BODY, 'h31));
    step(); #1; chk("t2_tail", oflit, fl(TAIL, 'h32));
    step(); #1;
    chk("t2_idle", busy, 0);
    chk("t2_nodrop", dropped, 0);

    // single flit
    pkt = mk(1, 4, 1); pvalid = 1'b1; #1;
    chk("t3_pop", completed, 1);
    step(); pvalid = 1'b0; #1;
    chk("t3_f0", oflit, fl(HEADTAIL, 'h40));
    step(); #1;
    chk("t3_idle", busy, 0);
    chk("t3_novalid", ovalid, 0);

    // long stall after flit 0
    pkt = mk(4, 5, 4); pvalid = 1'b1; #1;
    step(); pvalid = 1'b0; #1; chk("t5_f0", oflit, fl(HEAD, 'h50));
    step(); oready = 1'b0; #1; chk("t5_s1", oflit, fl(BODY, 'h51));
    step(); #1; chk("t5_s2", ovalid, 1);
    step(); #1; chk("t5_s3", ovalid, 1);
    step(); #1; chk("t5_s4", ovalid, 1);
    step();
`ifdef PACKET_FORWARDER_STALL_TIMEOUT_EN
    pkt = mk(2, 6, 2); pvalid = 1'b1; oready = 1'b1; #1;
    chk("t5_abort_valid", ovalid, 0);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_drop", dropped, 1);
    chk("t5_next_pop", completed, 1);
    step(); pvalid = 1'b0; #1; chk("t5_n0", oflit, fl(HEAD, 'h60));
    step(); #1; chk("t5_n1", oflit, fl(TAIL, 'h61));
    step(); #1; chk("t5_end", busy, 0);
`else
    for (int i = 0; i < 75; i++) step();
    #1;
    chk("t5_wait_valid", ovalid, 1);
    chk("t5_wait_flit", oflit, fl(BODY, 'h51));
    chk("t5_wait_drop", dropped, 0);
    oready = 1'b1;
    step(); #1; chk("t5_f2", oflit, fl(BODY, 'h52));
    step(); #1; chk("t5_f3", oflit, fl(TAIL, 'h53));
    step(); #1; chk("t5_end", busy, 0);
`endif

    // illegal lengths, then saturation
    pkt = mk(0, 0, 0); pvalid = 1'b1; #1;
    chk("t4_pop0", completed, 1);
    step(); pkt = mk(8, 0, 9); #1;
    chk("t4_d1", dropped, BASE + 1);
    chk("t4_nov1", ovalid, 0);
    chk("t4_pop9", completed, 1);
    step(); pkt = mk(8, 0, 17); #1;
    chk("t4_d2", dropped, BASE + 2);
    chk("t4_nov2", ovalid, 0);
    step(); pkt = mk(8, 0, 255); #1;
    chk("t4_d3", dropped, 3);
    chk("t4_nov17", busy, 0);
    step(); pvalid = 1'b0; #1;
    chk("t4_sat", dropped, 3);

    // maximum legal length
    step();
    pkt = mk(8, 7, 8); pvalid = 1'b1; #1;
    step(); pvalid = 1'b0; #1; chk("t7_f0", oflit, fl(HEAD, 'h70));
    for (int i = 0; i < 7; i++) step();
    #1; chk("t7_f7", oflit, fl(TAIL, 'h77));
    step(); #1;
    chk("t7_idle", busy, 0);
    chk("t7_drop", dropped, 3);

    // reset with flit 2 of 5 pending
    pkt = mk(5, 8, 5); pvalid = 1'b1; #1;
    step(); pvalid = 1'b0; #1;
    step(); #1;
    step(); oready = 1'b0; pkt = mk(3, 10, 3); pvalid = 1'b1; #1;
    chk("t6_f2", oflit, fl(BODY, 'h82));
    chk("t6_ignored", completed, 0);
    rst = 1'b1; #1;
    chk("t6_valid", ovalid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_completed", completed, 0);
    chk("t6_dropped", dropped, 0);
    pvalid = 1'b0;
    step();
    step();
    @(negedge nocclk); #1;
    rst = 1'b0;
    step();
    pkt = mk(2, 9, 2); pvalid = 1'b1; oready = 1'b1; #1;
    chk("t6_pop", completed, 1);
    step(); pvalid = 1'b0; #1; chk("t6_n0", oflit, fl(HEAD, 'h90));
    step(); #1; chk("t6_n1", oflit, fl(TAIL, 'h91));
    step(); #1;
    chk("t6_idle", busy, 0);
    chk("t6_nodrop", dropped, 0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
